regfile_param_seqclr: RTL and testbench
=======================================

// Module: regfile_param_seqclr
// PURPOSE
//  Parametrised 2-read/1-write register file for the single-cycle MIPS datapath.
//  Array is reset-free storage (maps to distributed RAM). Zeroing is done by an
//  internal clear sequencer, one entry per cycle, after reset or a clr request.
//  Adds an optional hardwired zero register, optional write-to-read bypass and a
//  busy flag so the control unit can stall while the clear runs.
// PARAMETERS
//  DATA_W    32             data width of each register
//  ADDR_W    5              address width
//  NUM_REGS  1<<ADDR_W      number of entries; must satisfy 2 <= NUM_REGS <= 2**ADDR_W
//  ZERO_REG  1              1: entry 0 always reads 0 and ignores writes
// PORTS
//  CLK         in   1        clock; all state updates on posedge
//  reset       in   1        synchronous, active-high reset
//  clr         in   1        request a full clear (sampled only when idle)
//  A1          in   ADDR_W   read address, port 1
//  A2          in   ADDR_W   read address, port 2
//  RD1         out  DATA_W   read data, port 1 (combinational)
//  RD2         out  DATA_W   read data, port 2 (combinational)
//  A3          in   ADDR_W   write address
//  WD3         in   DATA_W   write data
//  WE3         in   1        write enable
//  busy        out  1        clear in progress; writes dropped, reads return 0
//  wr_dropped  out  1        registered 1-cycle pulse: write attempted while busy
// BEHAVIOUR
//  State machine: IDLE, CLEAR. Clear pointer ptr is ADDR_W bits.
//  - reset=1 at posedge: state<=CLEAR, ptr<=0, busy<=1, wr_dropped<=0. Array untouched.
//    Holding reset keeps ptr at 0. Reset during CLEAR restarts from entry 0.
//  - CLEAR: each cycle regfile[ptr]<=0, ptr<=ptr+1. When ptr==NUM_REGS-1, that
//    entry is cleared and state<=IDLE, busy<=0. Clear lasts exactly NUM_REGS cycles
//    after reset deasserts; ptr never wraps past NUM_REGS-1.
//  - IDLE, clr=1: state<=CLEAR, ptr<=0, busy<=1 next cycle; a WE3 in the same cycle
//    as clr is still performed (then overwritten by the clear). clr during CLEAR ignored.
//  - Write: IDLE and WE3=1 -> regfile[A3]<=WD3 at posedge. ZERO_REG=1 and A3==0 ->
//    write discarded, no wr_dropped. A3 >= NUM_REGS -> write discarded.
//  - busy=1 and WE3=1 -> no array write; wr_dropped=1 in the following cycle.
//  - Read priority per port (RDn, An): busy -> 0; ZERO_REG and An==0 -> 0;
//    An >= NUM_REGS -> 0; bypass hit (see CONFIGURATION) -> WD3; else regfile[An].
//  - Read latency 0 (combinational); write visible to reads the cycle after posedge.
//  - Both read ports may use the same address; no port conflict exists.
//  - Output values after reset: busy=1, wr_dropped=0, RD1=RD2=0 until clear completes.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: if busy=0, WE3=1, A3==An, A3 < NUM_REGS and not
//    (ZERO_REG and A3==0), RDn returns WD3 in the same cycle (write-through forwarding).
//  REGFILE_BYPASS_EN undefined: RDn returns the old array content until the next
//    posedge; no combinational path from WD3/WE3/A3 to RD1/RD2.
// TESTING
//  1 reset 1 cycle, hold WE3=0 -> busy=1 for exactly 32 cycles, then 0; all RDn=0.
//  2 after clear: write A3=5 WD3=32'hDEADBEEF; next cycle A1=5 -> RD1=32'hDEADBEEF;
//    with REGFILE_BYPASS_EN, A1=5 in the write cycle also gives 32'hDEADBEEF, else 0.
//  3 ZERO_REG=1: write A3=0 WD3=32'h1234 -> A2=0 reads 0; wr_dropped stays 0.
//  4 WE3=1 A3=7 during CLEAR -> wr_dropped=1 next cycle; after clear RD1(A1=7)=0.
//  5 fill regs 1..31 with index value, pulse clr -> busy 32 cycles, all reads 0 after.
//  6 reset asserted at clear cycle 10 -> clear restarts, busy deasserts 32 cycles
//    after reset drops; NUM_REGS=24, ADDR_W=5: A1=30 reads 0, write to 30 ignored.

Source files
------------

// File: rtl/regfile_param_seqclr.sv
// ---------------------------------------------------------------------------
// regfile_param_seqclr
//   Parametrised 2-read / 1-write register file for a single-cycle MIPS
//   datapath. The storage array has no reset so it can map onto distributed
//   RAM. Zeroing is done by an internal clear sequencer that wipes one entry
//   per cycle after reset or after a clr request. While the clear runs, busy
//   is high, reads return 0 and writes are dropped (reported on wr_dropped).
//
// Parameters
//   DATA_W    data width of each register
//   ADDR_W    address width
//   NUM_REGS  number of entries, 2 <= NUM_REGS <= 2**ADDR_W
//   ZERO_REG  1: entry 0 always reads 0 and ignores writes
//
// Ports
//   CLK         in   clock, all state updates on posedge
//   reset       in   synchronous active-high reset (starts a full clear)
//   clr         in   full-clear request, sampled only when idle
//   A1 / RD1    in/out  read port 1 (combinational read)
//   A2 / RD2    in/out  read port 2 (combinational read)
//   A3/WD3/WE3  in   write port (write lands at posedge)
//   busy        out  clear in progress; this is the FSM state bit itself
//   wr_dropped  out  registered 1-cycle pulse: write attempted while busy
//
// Handshake: there is no valid/ready pair. The control unit must treat busy
//   as "not ready": any WE3 presented while busy=1 is discarded and flagged
//   on wr_dropped the following cycle; reads while busy=1 return 0.
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a read whose address matches an
//   accepted write in the same cycle returns WD3 (write-through forwarding).
//   When undefined there is no combinational path from the write port to
//   the read data.
// ---------------------------------------------------------------------------
module regfile_param_seqclr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 1 << ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              clr,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  output logic              busy,
  output logic              wr_dropped
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // One extra bit so NUM_REGS == 2**ADDR_W is representable for the
  // out-of-range comparisons.
  localparam logic [ADDR_W:0]   LP_NUM_REGS = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LP_LAST     = ADDR_W'(NUM_REGS - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_wr_dropped;
  logic [DATA_W-1:0] r_mem [NUM_REGS];

  logic w_idle;
  logic w_a1_ok;
  logic w_a2_ok;
  logic w_a3_ok;
  logic w_wr_en;
  logic w_byp1;
  logic w_byp2;

  assign w_idle = (r_state == ST_IDLE);

  // An address is "live" when it is inside the array and is not the
  // hardwired zero register.
  assign w_a1_ok = ({1'b0, A1} < LP_NUM_REGS) && !(ZERO_REG && (A1 == '0));
  assign w_a2_ok = ({1'b0, A2} < LP_NUM_REGS) && !(ZERO_REG && (A2 == '0));
  assign w_a3_ok = ({1'b0, A3} < LP_NUM_REGS) && !(ZERO_REG && (A3 == '0));

  // Accepted write: idle, enabled and targeting a live entry.
  assign w_wr_en = w_idle && WE3 && w_a3_ok;

`ifdef REGFILE_BYPASS_EN
  assign w_byp1 = w_wr_en && (A3 == A1);
  assign w_byp2 = w_wr_en && (A3 == A2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  // Clear sequencer. Reset (re)starts the clear at entry 0 and holds the
  // pointer there for as long as it is asserted; the array itself is not
  // touched in a reset cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= ST_CLEAR;
      r_ptr        <= '0;
      r_wr_dropped <= 1'b0;
    end else begin
      r_wr_dropped <= (r_state == ST_CLEAR) && WE3;
      case (r_state)
        ST_IDLE: begin
          if (clr) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
          end
        end
        ST_CLEAR: begin
          // Stop on the last entry instead of incrementing, so the pointer
          // never walks past NUM_REGS-1 even when NUM_REGS == 2**ADDR_W.
          if (r_ptr == LP_LAST) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  // Storage array, no reset. A write coinciding with clr is still
  // performed (the state is still idle in that cycle) and is then wiped
  // by the clear that follows.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_ptr] <= '0;
      end else if (w_wr_en) begin
        r_mem[A3] <= WD3;
      end
    end
  end

  // Read ports: busy / zero register / out of range all force 0.
  always_comb begin
    RD1 = '0;
    if (w_idle && w_a1_ok) begin
      if (w_byp1) begin
        RD1 = WD3;
      end else begin
        RD1 = r_mem[A1];
      end
    end
  end

  always_comb begin
    RD2 = '0;
    if (w_idle && w_a2_ok) begin
      if (w_byp2) begin
        RD2 = WD3;
      end else begin
        RD2 = r_mem[A2];
      end
    end
  end

  assign busy       = (r_state == ST_CLEAR);
  assign wr_dropped = r_wr_dropped;

endmodule

// File: tb/tb_regfile_param_seqclr.sv
// ---------------------------------------------------------------------------
// tb_regfile_param_seqclr
//   Two instances: dut 0 with the default 32 entries, dut 1 with 24 entries
//   (ADDR_W=5) for the out-of-range behaviour. Both share all inputs.
//   The reference model treats the clear as a countdown that zeroes the
//   whole array when it expires; individual entry wiping is invisible
//   because reads are forced to 0 while busy.
// ---------------------------------------------------------------------------
module tb_regfile_param_seqclr;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset block ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset;
  logic        clr;
  logic        WE3;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [4:0]  A3;
  logic [31:0] WD3;

  logic [31:0] rd1_o  [2];
  logic [31:0] rd2_o  [2];
  logic        busy_o [2];
  logic        wrd_o  [2];

  regfile_param_seqclr u_dut0 (
    .CLK(CLK), .reset(reset), .clr(clr),
    .A1(A1), .A2(A2), .RD1(rd1_o[0]), .RD2(rd2_o[0]),
    .A3(A3), .WD3(WD3), .WE3(WE3),
    .busy(busy_o[0]), .wr_dropped(wrd_o[0])
  );

  regfile_param_seqclr #(.NUM_REGS(24)) u_dut1 (
    .CLK(CLK), .reset(reset), .clr(clr),
    .A1(A1), .A2(A2), .RD1(rd1_o[1]), .RD2(rd2_o[1]),
    .A3(A3), .WD3(WD3), .WE3(WE3),
    .busy(busy_o[1]), .wr_dropped(wrd_o[1])
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_mem  [2][32];
  int          m_left [2];   // clear cycles still to run; 0 = idle
  bit          m_wrd  [2];
  int          m_n    [2];

  function automatic logic [31:0] m_read(int d, logic [4:0] a);
    if (m_left[d] > 0) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (int'(a) >= m_n[d]) return 32'h0;
    if (BYP && WE3 && (A3 == a)) return WD3;
    return m_mem[d][a];
  endfunction

  task automatic m_step();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_left[d] = m_n[d];
        m_wrd[d]  = 1'b0;
      end else if (m_left[d] > 0) begin
        m_wrd[d]  = WE3;
        m_left[d] = m_left[d] - 1;
        if (m_left[d] == 0)
          for (int i = 0; i < 32; i++) m_mem[d][i] = 32'h0;
      end else begin
        m_wrd[d] = 1'b0;
        if (WE3 && (A3 != 5'd0) && (int'(A3) < m_n[d])) m_mem[d][A3] = WD3;
        if (clr) m_left[d] = m_n[d];
      end
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s busy d%0d", tag, d), 32'(busy_o[d]), 32'(m_left[d] > 0));
      chk($sformatf("%s wr_dropped d%0d", tag, d), 32'(wrd_o[d]), 32'(m_wrd[d]));
      chk($sformatf("%s RD1 a=%0d d%0d", tag, A1, d), rd1_o[d], m_read(d, A1));
      chk($sformatf("%s RD2 a=%0d d%0d", tag, A2, d), rd2_o[d], m_read(d, A2));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(bit r, bit c, bit we, logic [4:0] a1, logic [4:0] a2,
                       logic [4:0] a3, logic [31:0] wd);
    reset = r; clr = c; WE3 = we; A1 = a1; A2 = a2; A3 = a3; WD3 = wd;
  endtask

  // Model advances at the same edge the DUT does, from the same inputs.
  task automatic tick();
    @(posedge CLK);
    m_step();
    @(negedge CLK);
  endtask

  // Idle inputs for a fixed 40 cycles (longer than any clear), counting
  // how many of those cycles each instance reports busy.
  task automatic run_idle(string tag, output int n0, output int n1);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), $urandom);
      #1;
      check_model(tag);
      n0 += int'(busy_o[0]);
      n1 += int'(busy_o[1]);
      tick();
    end
  endtask

  typedef struct {
    bit          we;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n0;
    int n1;
    logic [4:0] ra1;
    m_n[0] = 32; m_n[1] = 24;
    m_left[0] = 0; m_left[1] = 0;
    m_wrd[0] = 1'b0; m_wrd[1] = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) m_mem[d][i] = 32'h0;

    // Vectors start from an all-zero, idle array. Reads see pre-edge state.
    tbl[0] = '{1'b1, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, BYP ? 32'hDEADBEEF : 32'h0, 32'h0};
    tbl[1] = '{1'b1, 5'd5,  5'd0,  5'd0,  32'h00001234, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b0, 5'd0,  5'd5,  5'd0,  32'h0,        32'h0, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 5'd31, 5'd31, 5'd31, 32'hA5A5A5A5, BYP ? 32'hA5A5A5A5 : 32'h0,
                                                         BYP ? 32'hA5A5A5A5 : 32'h0};
    tbl[4] = '{1'b0, 5'd31, 5'd5,  5'd0,  32'h0,        32'hA5A5A5A5, 32'hDEADBEEF};
    tbl[5] = '{1'b1, 5'd5,  5'd5,  5'd5,  32'h00000001, BYP ? 32'h1 : 32'hDEADBEEF,
                                                         BYP ? 32'h1 : 32'hDEADBEEF};
    tbl[6] = '{1'b0, 5'd5,  5'd31, 5'd0,  32'h0,        32'h00000001, 32'hA5A5A5A5};

    // Reset for one cycle, then the clear runs with no writes.
    drive(1, 0, 0, 5'd3, 5'd4, 5'd0, 32'h0);
    tick();
    drive(0, 0, 0, 5'd3, 5'd4, 5'd0, 32'h0);
    #1;
    chk("reset busy", 32'(busy_o[0]), 32'h1);
    chk("reset wr_dropped", 32'(wrd_o[0]), 32'h0);
    chk("reset RD1", rd1_o[0], 32'h0);
    chk("reset RD2", rd2_o[0], 32'h0);
    run_idle("clear1", n0, n1);
    chk("busy length n32", 32'(n0), 32'd32);
    chk("busy length n24", 32'(n1), 32'd24);

    // Table-driven writes / reads / bypass on the 32-entry instance.
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, tbl[i].we, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].wd);
      #1;
      chk($sformatf("vec%0d RD1", i), rd1_o[0], tbl[i].e1);
      chk($sformatf("vec%0d RD2", i), rd2_o[0], tbl[i].e2);
      chk($sformatf("vec%0d busy", i), 32'(busy_o[0]), 32'h0);
      chk($sformatf("vec%0d wr_dropped", i), 32'(wrd_o[0]), 32'h0);
      check_model($sformatf("vec%0d", i));
      tick();
    end

    // Write attempted during a clear is dropped and flagged next cycle.
    drive(0, 1, 0, 5'd7, 5'd7, 5'd0, 32'h0);
    tick();
    drive(0, 0, 1, 5'd7, 5'd7, 5'd7, 32'h00000077);
    #1;
    check_model("drop");
    tick();
    drive(0, 0, 0, 5'd7, 5'd7, 5'd0, 32'h0);
    #1;
    chk("wr_dropped pulse", 32'(wrd_o[0]), 32'h1);
    check_model("drop+1");
    tick();
    #1;
    chk("wr_dropped cleared", 32'(wrd_o[0]), 32'h0);
    run_idle("clear2", n0, n1);
    drive(0, 0, 0, 5'd7, 5'd7, 5'd0, 32'h0);
    #1;
    chk("dropped entry reads 0", rd1_o[0], 32'h0);

    // Fill 1..31 with the index, read back, then clr and read all zero.
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 1, 5'd0, 5'd0, 5'(i), 32'(i));
      #1;
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 5'(i), 5'(31 - i), 5'd0, 32'h0);
      #1;
      chk($sformatf("fill RD1 a=%0d", i), rd1_o[0], 32'(i));
      check_model("fill");
    end
    drive(0, 1, 0, 5'd1, 5'd2, 5'd0, 32'h0);
    #1;
    tick();
    run_idle("clear3", n0, n1);
    chk("clr busy length n32", 32'(n0), 32'd32);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 5'(i), 5'(31 - i), 5'd0, 32'h0);
      #1;
      chk($sformatf("cleared RD1 a=%0d", i), rd1_o[0], 32'h0);
      chk($sformatf("cleared RD2 a=%0d", 31 - i), rd2_o[0], 32'h0);
    end

    // Reset arriving mid-clear restarts it from the beginning.
    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 5'd9, 5'd1, 5'd0, 32'h0);
      #1;
      check_model("pre-rerst");
      tick();
    end
    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0);
    tick();
    run_idle("clear4", n0, n1);
    chk("rerst busy length n32", 32'(n0), 32'd32);
    chk("rerst busy length n24", 32'(n1), 32'd24);

    // Address 30 is outside the 24-entry instance but inside the 32-entry one.
    drive(0, 0, 1, 5'd30, 5'd30, 5'd30, 32'hFFFF0030);
    #1;
    chk("n24 a30 write cycle", rd1_o[1], 32'h0);
    check_model("a30");
    tick();
    drive(0, 0, 0, 5'd30, 5'd23, 5'd0, 32'h0);
    #1;
    chk("n24 a30 read", rd1_o[1], 32'h0);
    chk("n32 a30 read", rd1_o[0], 32'hFFFF0030);
    chk("n24 a30 no drop", 32'(wrd_o[1]), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ra1 = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)), ra1, 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31)),
            $urandom);
      #1;
      check_model("rnd");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
